// File: rtl/dd_pkg.sv
// Shared types and helpers for the dd_radix_n tuple distributor.
// Holds the sideband layout stored alongside each tuple and the routing-field extractor.
package dd_pkg;

  localparam int unsigned TAG_W    = 32;
  localparam int unsigned SERIAL_W = 64;

  typedef struct packed {
    logic                last_processed;
    logic                was_joined;
    logic [SERIAL_W-1:0] serialnum;
    logic [TAG_W-1:0]    tag;
  } dd_side_t;

  // Routing field is tag[decision_bit -: log_ports], returned right-aligned.
  function automatic int unsigned dd_dest(input logic [TAG_W-1:0] tag,
                                          input int unsigned decision_bit,
                                          input int unsigned log_ports);
    logic [TAG_W-1:0] shifted;
    logic [TAG_W-1:0] mask;
    shifted = tag >> (decision_bit - log_ports + 1);
    mask    = (TAG_W'(1) << log_ports) - TAG_W'(1);
    return shifted & mask;
  endfunction

endpackage

// File: rtl/dd_out_fifo.sv
// Per-output valid/ready FIFO for dd_radix_n; a full FIFO accepts a push in the same
// cycle it is popped. Storage is not reset, only pointers and count.
module dd_out_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  output logic             space_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;
  assign space_o = (count_q < CntW'(Depth)) || pop;
  assign push    = push_i && space_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dd_radix_n.sv
// dd_radix_n: single-stage N-way tuple distributor with per-output round-robin arbiter and FIFO.
// Define DD_RADIX_STATS_EN to add per-output pop counters on stat_count.
module dd_radix_n
  import dd_pkg::*;
#(
  parameter int unsigned INPUT_SIZE   = 64,
  parameter int unsigned LOG_PORTS    = 2,
  parameter int unsigned DECISION_BIT = 1,
  parameter int unsigned FIFO_DEPTH   = 2,
  localparam int unsigned NUM_PORTS   = 1 << LOG_PORTS
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  output logic [NUM_PORTS-1:0]                  in_ready,
  input  logic [NUM_PORTS-1:0][INPUT_SIZE-1:0]  in_data,
  input  logic [NUM_PORTS-1:0][TAG_W-1:0]       in_tag,
  input  logic [NUM_PORTS-1:0]                  in_valid,
  input  logic [NUM_PORTS-1:0]                  in_last_processed,
  input  logic [NUM_PORTS-1:0][SERIAL_W-1:0]    in_serialnum,
  input  logic [NUM_PORTS-1:0]                  in_was_joined,
  input  logic [NUM_PORTS-1:0]                  out_ready,
  output logic [NUM_PORTS-1:0][INPUT_SIZE-1:0]  out_data,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]       out_tag,
  output logic [NUM_PORTS-1:0]                  out_last_processed,
  output logic [NUM_PORTS-1:0][SERIAL_W-1:0]    out_serialnum,
  output logic [NUM_PORTS-1:0]                  out_was_joined,
`ifdef DD_RADIX_STATS_EN
  output logic [NUM_PORTS-1:0][31:0]            stat_count,
`endif
  output logic [NUM_PORTS-1:0]                  out_valid
);

  localparam int unsigned SideW  = $bits(dd_side_t);
  localparam int unsigned EntryW = INPUT_SIZE + SideW;

  typedef logic [LOG_PORTS-1:0] idx_t;

  idx_t [NUM_PORTS-1:0] dest;
  idx_t [NUM_PORTS-1:0] grant_idx;
  logic [NUM_PORTS-1:0] push;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_dest
    assign dest[i] = idx_t'(dd_dest(in_tag[i], DECISION_BIT, LOG_PORTS));
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    idx_t              rr_q, rr_d, gnt_idx;
    logic              gnt_vld, space;
    dd_side_t          wside, rside;
    logic [EntryW-1:0] wdata, rdata;

    // First requester at or after the pointer, wrapping modulo NUM_PORTS.
    always_comb begin
      idx_t cand;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = rr_q + idx_t'(k);
        if (!gnt_vld && in_valid[cand] && (dest[cand] == idx_t'(j))) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end

    assign push[j]      = gnt_vld && space && resetn;
    assign grant_idx[j] = gnt_idx;

    always_comb begin
      rr_d = rr_q;
      if (push[j]) rr_d = gnt_idx + idx_t'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rr_q <= '0;
      else         rr_q <= rr_d;
    end

    always_comb begin
      wside.last_processed = in_last_processed[gnt_idx];
      wside.was_joined     = in_was_joined[gnt_idx];
      wside.serialnum      = in_serialnum[gnt_idx];
      wside.tag            = in_tag[gnt_idx];
    end

    assign wdata = {in_data[gnt_idx], wside};

    dd_out_fifo #(
      .Width(EntryW),
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk_i  (clk),
      .rst_ni (resetn),
      .push_i (push[j]),
      .wdata_i(wdata),
      .space_o(space),
      .valid_o(out_valid[j]),
      .ready_i(out_ready[j]),
      .rdata_o(rdata)
    );

    assign rside                 = dd_side_t'(rdata[SideW-1:0]);
    assign out_data[j]           = rdata[EntryW-1 -: INPUT_SIZE];
    assign out_tag[j]            = rside.tag;
    assign out_serialnum[j]      = rside.serialnum;
    // Flags must read 0 while the slot is empty since storage is never cleared.
    assign out_last_processed[j] = rside.last_processed & out_valid[j];
    assign out_was_joined[j]     = rside.was_joined & out_valid[j];

`ifdef DD_RADIX_STATS_EN
    logic [31:0] stat_q, stat_d;

    always_comb begin
      stat_d = stat_q;
      if (out_valid[j] && out_ready[j]) stat_d = stat_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) stat_q <= '0;
      else         stat_q <= stat_d;
    end

    assign stat_count[j] = stat_q;
`endif
  end

  // Each input targets exactly one output, so at most one grant can name it.
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (push[j]) in_ready[grant_idx[j]] = 1'b1;
    end
  end

endmodule
